// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Operation encoding matches RV32M func3 so decode can cast directly.
// Latency helper lets pipeline control size stall windows per configuration.
package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // Accept-to-valid latency for a non-special op: one cycle per iteration plus the accept cycle.
  function automatic int md_latency(input int xlen, input int unroll);
    return xlen / unroll + 1;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_md_step.sv
// One radix-2 iteration shared by multiply (shift-add) and divide (restoring shift-subtract).
// Purely combinational; chained to retire several bits per clock.
// No flow control of its own; the owning FSM decides when results are taken.
module ex_muldiv_unit_md_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_m,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          ge;

  // Multiply: {hi,lo} is the accumulator with the multiplier draining out of lo.
  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : '0);
    trial = {i_hi, i_lo[XLEN-1]};
    // Remainder stays below the divisor, so trial < 2*divisor and the borrow bit is exact.
    diff  = trial - {1'b0, i_m};
    ge    = ~diff[XLEN];
    if (i_div) begin
      o_hi = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], ge};
    end else begin
      o_hi = sum[XLEN:1];
      o_lo = {sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU beside the EX-stage ALU.
// Latency XLEN/UNROLL+1 cycles from accept to o_valid; div-by-zero and MIN/-1 take 1 cycle.
// Holds result while i_ready=0; o_ready only in IDLE; i_flush squashes the in-flight op.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int ITERS = XLEN / UNROLL;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state_q, state_d;
  md_op_t          op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] m_q, m_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  md_op_t          op_in;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            is_special;
  logic [XLEN-1:0] special_res;

  // Accept-side decode: operand signedness, magnitudes and the fixed-result corner cases.
  always_comb begin
    op_in       = md_op_t'(i_func3);
    sign_a      = i_A[XLEN-1] & ~(op_in inside {MD_MULHU, MD_DIVU, MD_REMU});
    sign_b      = i_B[XLEN-1] & (op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
    mag_a       = sign_a ? -i_A : i_A;
    mag_b       = sign_b ? -i_B : i_B;
    is_special  = 1'b0;
    special_res = '0;
    if (op_in[2]) begin
      if (i_B == '0) begin
        is_special  = 1'b1;
        special_res = op_in[1] ? i_A : '1;
      end else if (!op_in[0] && i_A == MIN_VAL && i_B == '1) begin
        is_special  = 1'b1;
        special_res = op_in[1] ? '0 : MIN_VAL;
      end
    end
  end

  // Iteration chain: UNROLL single-bit steps per clock.
  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    logic [XLEN-1:0] hi_in, lo_in, hi_out, lo_out;
    if (g == 0) begin : g_first
      assign hi_in = hi_q;
      assign lo_in = lo_q;
    end else begin : g_next
      assign hi_in = g_step[g-1].hi_out;
      assign lo_in = g_step[g-1].lo_out;
    end
    ex_muldiv_unit_md_step #(.XLEN(XLEN)) u_step (
      .i_div (op_q[2]),
      .i_hi  (hi_in),
      .i_lo  (lo_in),
      .i_m   (m_q),
      .o_hi  (hi_out),
      .o_lo  (lo_out)
    );
  end

  logic [XLEN-1:0]   fin_hi, fin_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   final_res;

  assign fin_hi = g_step[UNROLL-1].hi_out;
  assign fin_lo = g_step[UNROLL-1].lo_out;

  // Sign fix-up on the last iteration's output; product negation is modulo 2^(2*XLEN).
  always_comb begin
    prod = neg_q ? -{fin_hi, fin_lo} : {fin_hi, fin_lo};
    case (op_q)
      MD_MUL:                      final_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             final_res = neg_q ? -fin_lo : fin_lo;
      default:                     final_res = neg_q ? -fin_hi : fin_hi;
    endcase
  end

  // Next-state and datapath load; flush overrides every transition.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && !i_flush) begin
          op_d  = op_in;
          // REM takes the dividend's sign; everything else the XOR of operand signs.
          neg_d = (op_in == MD_REM) ? sign_a : (sign_a ^ sign_b);
          if (is_special) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = op_in[2] ? mag_a : mag_b;
            m_d     = op_in[2] ? mag_b : mag_a;
            cnt_d   = CW'(ITERS);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        hi_d  = fin_hi;
        lo_d  = fin_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = final_res;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) state_d = ST_IDLE;
  end

  // State and datapath registers; async reset clears everything including the result.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: XLEN=32 with UNROLL=1 and UNROLL=4 instances.
// Expected values are hand-computed RV32M results and latencies.
// Inputs driven just after the rising edge, outputs sampled on the falling edge.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // UNROLL=1 instance
  logic        valid1 = 1'b0, rdy1 = 1'b1, flush1 = 1'b0;
  logic [2:0]  func1 = 3'd0;
  logic [31:0] a1 = '0, b1 = '0;
  logic        ready1, ov1, busy1;
  logic [31:0] r1;

  // UNROLL=4 instance
  logic        valid4 = 1'b0, rdy4 = 1'b1, flush4 = 1'b0;
  logic [2:0]  func4 = 3'd0;
  logic [31:0] a4 = '0, b4 = '0;
  logic        ready4, ov4, busy4;
  logic [31:0] r4;

  int cmp_count = 0;
  int err_count = 0;

  ex_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid1), .o_ready(ready1), .i_func3(func1),
    .i_A(a1), .i_B(b1), .i_flush(flush1), .o_valid(ov1), .i_ready(rdy1),
    .o_result(r1), .o_busy(busy1)
  );

  ex_muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid4), .o_ready(ready4), .i_func3(func4),
    .i_A(a4), .i_B(b4), .i_flush(flush4), .o_valid(ov4), .i_ready(rdy4),
    .o_result(r4), .o_busy(busy4)
  );

  // Issue one op, scramble the inputs right after accept, and return the result and the
  // cycle (relative to the accept cycle) at which o_valid first rose; 999 if it never did.
  task automatic do_op(input int sel, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output logic [31:0] res);
    @(negedge clk);
    if (sel == 4) begin valid4 = 1'b1; func4 = f; a4 = a; b4 = b; end
    else          begin valid1 = 1'b1; func1 = f; a1 = a; b1 = b; end
    @(posedge clk); #1;
    if (sel == 4) begin valid4 = 1'b0; func4 = ~f; a4 = 32'hDEADBEEF; b4 = 32'h1234; end
    else          begin valid1 = 1'b0; func1 = ~f; a1 = 32'hDEADBEEF; b1 = 32'h1234; end
    lat = 999;
    res = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if ((sel == 4) ? ov4 : ov1) begin
        lat = k;
        res = (sel == 4) ? r4 : r1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    cmp_count++; if (ready1 !== 1'b1) begin err_count++; $display("FAIL reset_ready: got %b want 1", ready1); end
    cmp_count++; if (ov1 !== 1'b0) begin err_count++; $display("FAIL reset_valid: got %b want 0", ov1); end
    cmp_count++; if (busy1 !== 1'b0) begin err_count++; $display("FAIL reset_busy: got %b want 0", busy1); end
    cmp_count++; if (r1 !== 32'h0) begin err_count++; $display("FAIL reset_result: got %h want 0", r1); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] res;
    do_op(1, 3'b000, 32'd7, 32'hFFFFFFFD, lat, res);
    cmp_count++; if (res !== 32'hFFFFFFEB) begin err_count++; $display("FAIL mul_result: got %h want ffffffeb", res); end
    cmp_count++; if (lat !== 33) begin err_count++; $display("FAIL mul_latency: got %0d want 33", lat); end
    @(negedge clk);
    cmp_count++; if (ov1 !== 1'b0 || ready1 !== 1'b1) begin err_count++; $display("FAIL mul_one_cycle: valid %b ready %b want 0 1", ov1, ready1); end
  endtask

  task automatic test_mulh();
    logic [2:0]  fs [4] = '{3'b011, 3'b001, 3'b010, 3'b001};
    logic [31:0] as [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] bs [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h80000000};
    logic [31:0] ex [4] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h40000000};
    int lat; logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      do_op(1, fs[i], as[i], bs[i], lat, res);
      cmp_count++; if (res !== ex[i] || lat !== 33) begin err_count++; $display("FAIL mulh_%0d: got %h lat %0d want %h lat 33", i, res, lat, ex[i]); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  fs [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as [4] = '{32'h80000000, 32'h80000000, 32'd13, 32'd13};
    logic [31:0] bs [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] ex [4] = '{32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'd13};
    int lat; logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      do_op(1, fs[i], as[i], bs[i], lat, res);
      cmp_count++; if (res !== ex[i]) begin err_count++; $display("FAIL special_res_%0d: got %h want %h", i, res, ex[i]); end
      cmp_count++; if (lat !== 1) begin err_count++; $display("FAIL special_lat_%0d: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_signed_div();
    logic [2:0]  fs [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bs [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    int lat; logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      do_op(1, fs[i], as[i], bs[i], lat, res);
      cmp_count++; if (res !== ex[i] || lat !== 33) begin err_count++; $display("FAIL div_%0d: got %h lat %0d want %h lat 33", i, res, lat, ex[i]); end
    end
  endtask

  task automatic test_unroll4();
    logic [2:0]  fs [3] = '{3'b100, 3'b110, 3'b000};
    logic [31:0] as [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7};
    logic [31:0] bs [3] = '{32'd2, 32'd2, 32'hFFFFFFFD};
    logic [31:0] ex [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    int lat; logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      do_op(4, fs[i], as[i], bs[i], lat, res);
      cmp_count++; if (res !== ex[i]) begin err_count++; $display("FAIL u4_res_%0d: got %h want %h", i, res, ex[i]); end
      cmp_count++; if (lat !== 9) begin err_count++; $display("FAIL u4_lat_%0d: got %0d want 9", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] res;
    rdy1 = 1'b0;
    do_op(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
    cmp_count++; if (res !== 32'hFFFFFFFE) begin err_count++; $display("FAIL bp_result: got %h want fffffffe", res); end
    // A competing request while the result is stalled must be ignored.
    valid1 = 1'b1; func1 = 3'b000; a1 = 32'd3; b1 = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp_count++;
      if (ov1 !== 1'b1 || ready1 !== 1'b0 || r1 !== 32'hFFFFFFFE) begin
        err_count++; $display("FAIL bp_hold_%0d: valid %b ready %b result %h want 1 0 fffffffe", i, ov1, ready1, r1);
      end
    end
    valid1 = 1'b0; rdy1 = 1'b1;
    @(negedge clk);
    cmp_count++; if (ov1 !== 1'b0 || ready1 !== 1'b1 || busy1 !== 1'b0) begin err_count++; $display("FAIL bp_retire: valid %b ready %b busy %b want 0 1 0", ov1, ready1, busy1); end
  endtask

  task automatic test_flush();
    int lat; int seen; logic [31:0] res;
    @(negedge clk);
    valid1 = 1'b1; func1 = 3'b101; a1 = 32'd100; b1 = 32'd7;
    @(posedge clk); #1 valid1 = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush1 = 1'b1;
    @(posedge clk); #1 flush1 = 1'b0;
    @(negedge clk);
    cmp_count++; if (ready1 !== 1'b1 || ov1 !== 1'b0 || busy1 !== 1'b0) begin err_count++; $display("FAIL flush_idle: ready %b valid %b busy %b want 1 0 0", ready1, ov1, busy1); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (ov1) seen++; end
    cmp_count++; if (seen !== 0) begin err_count++; $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen); end
    do_op(1, 3'b101, 32'd100, 32'd7, lat, res);
    cmp_count++; if (res !== 32'd14 || lat !== 33) begin err_count++; $display("FAIL flush_next_op: got %h lat %0d want 0000000e lat 33", res, lat); end
  endtask

  task automatic test_reset_midop();
    int lat; int seen; logic [31:0] res;
    @(negedge clk);
    valid1 = 1'b1; func1 = 3'b101; a1 = 32'd100; b1 = 32'd7;
    @(posedge clk); #1 valid1 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    cmp_count++; if (ready1 !== 1'b1 || ov1 !== 1'b0 || busy1 !== 1'b0 || r1 !== 32'h0) begin
      err_count++; $display("FAIL reset_midop: ready %b valid %b busy %b result %h want 1 0 0 0", ready1, ov1, busy1, r1);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (ov1) seen++; end
    cmp_count++; if (seen !== 0) begin err_count++; $display("FAIL reset_no_residual: got %0d valid cycles want 0", seen); end
    do_op(1, 3'b000, 32'd6, 32'd7, lat, res);
    cmp_count++; if (res !== 32'd42 || lat !== 33) begin err_count++; $display("FAIL reset_next_op: got %h lat %0d want 0000002a lat 33", res, lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_special();
    test_signed_div();
    test_unroll4();
    test_backpressure();
    test_flush();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
